sample_rate_gen: RTL and testbench

Programmable request-rate generator for the G-sensor read path; the producing end of the data-valid rate interface whose consuming end counts valid pulses per second. It issues read requests to the sensor SPI controller at a programmed number of requests per second. Requests are spread evenly across each second using a fractional phase accumulator. It reports requests missed because the controller was still busy with the previous one.

---
 rtl/sample_rate_gen_if.sv | 30 +++
 rtl/sample_rate_gen.sv | 109 ++++++++++
 tb/tb_sample_rate_gen.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_rate_gen_if.sv
// Request/ack and status bundle between the rate generator and the SPI read path.
interface sample_rate_gen_if;
   logic        iEnable;
   logic [15:0] iRateSec;
   logic        iAck;
   logic        oReq;
   logic [15:0] oReqCnt;
   logic [15:0] oMissCnt;
   logic        oActive;

   modport master (
      input  iEnable,
      input  iRateSec,
      input  iAck,
      output oReq,
      output oReqCnt,
      output oMissCnt,
      output oActive
   );

   modport slave (
      output iEnable,
      output iRateSec,
      output iAck,
      input  oReq,
      input  oReqCnt,
      input  oMissCnt,
      input  oActive
   );
endinterface

// File: rtl/sample_rate_gen.sv
// Issues sensor read requests at iRateSec per second, spread evenly by a phase accumulator
// modulo CLK_HZ; counts accepted requests and ticks dropped while one was still pending.
module sample_rate_gen #(
   parameter int unsigned CLK_HZ = 50000000,
   parameter int unsigned ACC_W  = 32
) (
   input  logic              iClk50M,
   input  logic              iRst_n,
   sample_rate_gen_if.master bus
);

   typedef enum logic {StIdle, StRun} state_e;

   localparam logic [ACC_W-1:0] LP_MOD = ACC_W'(CLK_HZ);

   state_e           r_state, w_state_nxt;
   logic [ACC_W-1:0] r_acc, w_acc_nxt;
   logic [15:0]      r_rate, w_rate_nxt;
   logic             r_req, w_req_nxt;
   logic [15:0]      r_req_cnt, w_req_cnt_nxt;
   logic [15:0]      r_miss_cnt, w_miss_cnt_nxt;

   logic [ACC_W-1:0] w_sum;
   logic             w_tick;
   logic             w_exit;
   logic             w_accept;

   assign w_sum    = r_acc + ACC_W'(r_rate);
   assign w_accept = r_req & bus.iAck;

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_rate_nxt  = r_rate;
      w_tick      = 1'b0;
      w_exit      = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (bus.iEnable) begin
               w_state_nxt = StRun;
               w_acc_nxt   = '0;
               w_rate_nxt  = bus.iRateSec;
            end
         end
         StRun: begin
            if (!bus.iEnable) begin
               w_state_nxt = StIdle;
               w_acc_nxt   = '0;
               w_exit      = 1'b1;
            end else if (bus.iRateSec != r_rate) begin
               // Restart the phase so the new rate takes effect cleanly next cycle.
               w_rate_nxt = bus.iRateSec;
               w_acc_nxt  = '0;
            end else if (w_sum >= LP_MOD) begin
               w_tick    = 1'b1;
               w_acc_nxt = w_sum - LP_MOD;
            end else begin
               w_acc_nxt = w_sum;
            end
         end
      endcase
   end

   always_comb begin
      w_req_nxt      = r_req;
      w_miss_cnt_nxt = r_miss_cnt;
      w_req_cnt_nxt  = r_req_cnt;
      if (w_accept) begin
         w_req_cnt_nxt = r_req_cnt + 16'd1;
      end
      if (w_tick && (!r_req || w_accept)) begin
         w_req_nxt = 1'b1;
      end else if (w_tick) begin
         // Controller still busy: the tick is dropped, never queued.
         if (r_miss_cnt != 16'hFFFF) begin
            w_miss_cnt_nxt = r_miss_cnt + 16'd1;
         end
      end else if (w_accept) begin
         w_req_nxt = 1'b0;
      end
      if (w_exit) begin
         w_req_nxt = 1'b0;
      end
   end

   always_ff @(posedge iClk50M or negedge iRst_n) begin
      if (!iRst_n) begin
         r_state    <= StIdle;
         r_acc      <= '0;
         r_rate     <= '0;
         r_req      <= 1'b0;
         r_req_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_acc      <= w_acc_nxt;
         r_rate     <= w_rate_nxt;
         r_req      <= w_req_nxt;
         r_req_cnt  <= w_req_cnt_nxt;
         r_miss_cnt <= w_miss_cnt_nxt;
      end
   end

   assign bus.oReq     = r_req;
   assign bus.oReqCnt  = r_req_cnt;
   assign bus.oMissCnt = r_miss_cnt;
   assign bus.oActive  = (r_state == StRun);

endmodule

// File: tb/tb_sample_rate_gen.sv
// Bench for sample_rate_gen: directed scenarios with literal expectations plus random traffic,
// all cycles checked against a model that derives ticks from floor(k*rate/CLK_HZ) steps.
module tb_sample_rate_gen;

   localparam int unsigned CLK_HZ = 1000;
   localparam longint      LCLK   = 1000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sample_rate_gen_if bus ();

   sample_rate_gen #(
      .CLK_HZ(CLK_HZ),
      .ACC_W (32)
   ) dut (
      .iClk50M(clk),
      .iRst_n (rst_n),
      .bus    (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   bit auto_ack = 1'b0;

   // Reference model state
   logic        m_run;
   longint      m_k;
   longint      m_rate;
   logic        m_req;
   logic [15:0] m_rcnt;
   logic [15:0] m_miss;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin : mdl
      logic   acc, tick, ex;
      longint k_n, rate_n;
      logic   run_n, req_n;
      logic [15:0] miss_n;
      if (!rst_n) begin
         m_run  <= 1'b0;
         m_k    <= 0;
         m_rate <= 0;
         m_req  <= 1'b0;
         m_rcnt <= '0;
         m_miss <= '0;
      end else begin
         acc    = m_req & bus.iAck;
         tick   = 1'b0;
         ex     = 1'b0;
         k_n    = m_k;
         rate_n = m_rate;
         run_n  = m_run;
         if (!m_run) begin
            if (bus.iEnable) begin
               run_n  = 1'b1;
               k_n    = 0;
               rate_n = longint'(bus.iRateSec);
            end
         end else if (!bus.iEnable) begin
            run_n = 1'b0;
            ex    = 1'b1;
         end else if (longint'(bus.iRateSec) != m_rate) begin
            rate_n = longint'(bus.iRateSec);
            k_n    = 0;
         end else begin
            k_n  = m_k + 1;
            tick = ((k_n * m_rate) / LCLK) != (((k_n - 1) * m_rate) / LCLK);
         end
         req_n  = m_req;
         miss_n = m_miss;
         if (tick && (!m_req || acc)) req_n = 1'b1;
         else if (tick) miss_n = (m_miss == 16'hFFFF) ? m_miss : m_miss + 16'd1;
         else if (acc) req_n = 1'b0;
         if (ex) req_n = 1'b0;
         m_run  <= run_n;
         m_k    <= k_n;
         m_rate <= rate_n;
         m_req  <= req_n;
         m_miss <= miss_n;
         m_rcnt <= m_rcnt + {15'd0, acc};
      end
   end

   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         chk("model_req", {31'd0, bus.oReq}, {31'd0, m_req});
         chk("model_active", {31'd0, bus.oActive}, {31'd0, m_run});
         chk("model_reqcnt", {16'd0, bus.oReqCnt}, {16'd0, m_rcnt});
         chk("model_misscnt", {16'd0, bus.oMissCnt}, {16'd0, m_miss});
      end
   end

   always @(negedge clk) begin
      if (auto_ack) bus.iAck = bus.oReq;
   end

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n        = 1'b0;
      auto_ack     = 1'b0;
      bus.iEnable  = 1'b0;
      bus.iAck     = 1'b0;
      bus.iRateSec = 16'd0;
      #12;
      rst_n = 1'b1;
      edges(1);
   endtask

   // Edges until oReq goes from low to high; n = 99 on timeout.
   task automatic wait_rise(output int n);
      logic prev;
      prev = bus.oReq;
      n    = 0;
      while (n < 60) begin
         edges(1);
         n++;
         if (bus.oReq && !prev) return;
         prev = bus.oReq;
      end
      n = 99;
   endtask

   initial begin
      int n;
      int e;
      int exp_seq[5];
      logic [15:0] snap_cnt, snap_miss;

      bus.iEnable  = 1'b0;
      bus.iRateSec = 16'd0;
      bus.iAck     = 1'b0;

      // Idle: enable low, rate programmed
      do_reset();
      bus.iRateSec = 16'd250;
      edges(2000);
      chk("idle_req", {31'd0, bus.oReq}, 32'd0);
      chk("idle_reqcnt", {16'd0, bus.oReqCnt}, 32'd0);
      chk("idle_misscnt", {16'd0, bus.oMissCnt}, 32'd0);
      chk("idle_active", {31'd0, bus.oActive}, 32'd0);

      // Even rate 250
      do_reset();
      bus.iRateSec = 16'd250;
      auto_ack     = 1'b1;
      bus.iEnable  = 1'b1;
      wait_rise(n);
      chk("even_first_rise", n, 32'd5);
      e = n;
      wait_rise(n);
      chk("even_spacing", n, 32'd4);
      e += n;
      edges(1002 - e);
      chk("even_reqcnt_1000", {16'd0, bus.oReqCnt}, 32'd250);
      chk("even_misscnt", {16'd0, bus.oMissCnt}, 32'd0);

      // Fractional rate 300: spacing 4,3,3 pattern, no drift
      do_reset();
      bus.iRateSec = 16'd300;
      auto_ack     = 1'b1;
      bus.iEnable  = 1'b1;
      wait_rise(n);
      chk("frac_first_rise", n, 32'd5);
      e = n;
      exp_seq = '{3, 3, 4, 3, 3};
      for (int i = 0; i < 5; i++) begin
         wait_rise(n);
         chk($sformatf("frac_spacing_%0d", i), n, exp_seq[i]);
         e += n;
      end
      edges(10002 - e);
      chk("frac_reqcnt_10000", {16'd0, bus.oReqCnt}, 32'd3000);
      chk("frac_misscnt", {16'd0, bus.oMissCnt}, 32'd0);

      // Busy controller, then saturation
      do_reset();
      bus.iRateSec = 16'd250;
      bus.iEnable  = 1'b1;
      edges(41);
      chk("busy_req", {31'd0, bus.oReq}, 32'd1);
      chk("busy_misscnt", {16'd0, bus.oMissCnt}, 32'd9);
      chk("busy_reqcnt0", {16'd0, bus.oReqCnt}, 32'd0);
      bus.iAck = 1'b1;
      edges(1);
      bus.iAck = 1'b0;
      chk("busy_reqcnt1", {16'd0, bus.oReqCnt}, 32'd1);
      chk("busy_req_after_ack", {31'd0, bus.oReq}, 32'd0);
      bus.iRateSec = 16'd1000;
      edges(66000);
      chk("sat_misscnt", {16'd0, bus.oMissCnt}, 32'hFFFF);
      chk("sat_req", {31'd0, bus.oReq}, 32'd1);

      // Simultaneous ack+tick, then rate change 250->500
      do_reset();
      bus.iRateSec = 16'd250;
      bus.iEnable  = 1'b1;
      edges(8);
      chk("sim_req_pending", {31'd0, bus.oReq}, 32'd1);
      bus.iAck = 1'b1;
      edges(1);
      chk("sim_req_held", {31'd0, bus.oReq}, 32'd1);
      chk("sim_reqcnt", {16'd0, bus.oReqCnt}, 32'd1);
      chk("sim_misscnt", {16'd0, bus.oMissCnt}, 32'd0);
      bus.iRateSec = 16'd500;
      edges(1);
      bus.iAck = 1'b0;
      chk("rc_req_cleared", {31'd0, bus.oReq}, 32'd0);
      edges(1);
      chk("rc_no_tick_yet", {31'd0, bus.oReq}, 32'd0);
      edges(1);
      chk("rc_first_rise", {31'd0, bus.oReq}, 32'd1);
      auto_ack = 1'b1;
      edges(1);
      chk("rc_acked", {31'd0, bus.oReq}, 32'd0);
      edges(1);
      chk("rc_second_rise", {31'd0, bus.oReq}, 32'd1);

      // Disable while a request is pending, with simultaneous ack
      auto_ack  = 1'b0;
      bus.iAck  = 1'b0;
      snap_cnt  = m_rcnt;
      snap_miss = m_miss;
      bus.iEnable = 1'b0;
      bus.iAck    = 1'b1;
      edges(1);
      bus.iAck = 1'b0;
      chk("dis_req", {31'd0, bus.oReq}, 32'd0);
      chk("dis_active", {31'd0, bus.oActive}, 32'd0);
      chk("dis_reqcnt", {16'd0, bus.oReqCnt}, {16'd0, snap_cnt + 16'd1});
      chk("dis_misscnt", {16'd0, bus.oMissCnt}, {16'd0, snap_miss});

      // Asynchronous reset between edges
      bus.iEnable = 1'b1;
      edges(20);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_req", {31'd0, bus.oReq}, 32'd0);
      chk("arst_reqcnt", {16'd0, bus.oReqCnt}, 32'd0);
      chk("arst_misscnt", {16'd0, bus.oMissCnt}, 32'd0);
      chk("arst_active", {31'd0, bus.oActive}, 32'd0);
      #6;
      rst_n = 1'b1;
      edges(1);

      // Random traffic against the model
      do_reset();
      bus.iRateSec = 16'd300;
      bus.iEnable  = 1'b1;
      repeat (3000) begin
         if ($urandom_range(49) == 0) bus.iEnable = ~bus.iEnable;
         if ($urandom_range(99) == 0) begin
            case ($urandom_range(3))
               0: bus.iRateSec = 16'd0;
               1: bus.iRateSec = 16'd250;
               2: bus.iRateSec = 16'd1000;
               default: bus.iRateSec = 16'($urandom_range(999, 1));
            endcase
         end
         bus.iAck = 1'($urandom_range(1));
         edges(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
